// File: rtl/usb_phy_pkg.sv
// USB PHY receive-side shared constants and types.
// 10b codes, TS framing lengths, polarity FSM states.
package usb_phy_pkg;

  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] D102   = 10'b0101010101;
  localparam logic [9:0] D215   = 10'b1010101010;

  localparam int TS_HDR_LEN = 4;
  localparam int CHK_LEN    = 10;

  typedef enum logic [2:0] {
    HUNT,
    HDR,
    SKIP,
    CHECK,
    LOCKED
  } pol_st_t;

  function automatic logic is_k285(input logic [9:0] s);
    return (s == K285_N) || (s == K285_P);
  endfunction

endpackage

// File: rtl/usb_pol_det.sv
// Per-lane RX polarity detector: TS1/TS2 framing FSM
// with a saturating vote counter on the D10.2/D21.5 field.
import usb_phy_pkg::*;

module usb_pol_det #(
  parameter int VOTE_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym,
  input  logic       valid,
  input  logic       auto_en,
  input  logic       clr,
  output logic       lock,
  output logic       inv
);

  pol_st_t    st, st_d;
  logic [2:0] ccnt, ccnt_d;
  logic [3:0] idx, idx_d;
  logic       an, an_d;
  logic       ai, ai_d;
  logic [3:0] vcnt, vcnt_d;
  logic       sense, sense_d;
  logic       lock_d, inv_d;
  logic [3:0] nv;
  logic       fin_n, fin_i;

  localparam logic [3:0] VMAX = 4'(VOTE_CNT);

  assign fin_n = an & (sym == D102);
  assign fin_i = ai & (sym == D215);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= HUNT;
      ccnt  <= '0;
      idx   <= '0;
      an    <= 1'b0;
      ai    <= 1'b0;
      vcnt  <= '0;
      sense <= 1'b0;
      lock  <= 1'b0;
      inv   <= 1'b0;
    end else begin
      st    <= st_d;
      ccnt  <= ccnt_d;
      idx   <= idx_d;
      an    <= an_d;
      ai    <= ai_d;
      vcnt  <= vcnt_d;
      sense <= sense_d;
      lock  <= lock_d;
      inv   <= inv_d;
    end
  end

  always_comb begin
    st_d    = st;
    ccnt_d  = ccnt;
    idx_d   = idx;
    an_d    = an;
    ai_d    = ai;
    vcnt_d  = vcnt;
    sense_d = sense;
    lock_d  = lock;
    inv_d   = inv;
    nv      = vcnt;
    if (clr) begin
      st_d    = HUNT;
      ccnt_d  = '0;
      idx_d   = '0;
      vcnt_d  = '0;
      sense_d = 1'b0;
      lock_d  = 1'b0;
      inv_d   = 1'b0;
    end else begin
      unique case (st)
        HUNT: begin
          if (valid && is_k285(sym)) begin
            st_d   = HDR;
            ccnt_d = 3'd1;
          end
        end
        HDR: begin
          if (valid) begin
            if (is_k285(sym)) begin
              ccnt_d = ccnt + 3'd1;
              if (ccnt_d == 3'(TS_HDR_LEN))
                st_d = SKIP;
            end else begin
              st_d   = HUNT;
              ccnt_d = '0;
            end
          end
        end
        SKIP: begin
          if (valid) begin
            st_d   = CHECK;
            ccnt_d = '0;
            idx_d  = '0;
            an_d   = 1'b1;
            ai_d   = 1'b1;
          end
        end
        CHECK: begin
          if (valid) begin
            an_d  = fin_n;
            ai_d  = fin_i;
            idx_d = idx + 4'd1;
            if (idx == 4'(CHK_LEN - 1)) begin
              st_d  = HUNT;
              idx_d = '0;
              if (fin_n || fin_i) begin
                // A fresh or opposite verdict restarts the vote
                if (vcnt != 4'd0 && fin_i == sense)
                  nv = (vcnt >= VMAX) ? VMAX : vcnt + 4'd1;
                else
                  nv = 4'd1;
                vcnt_d  = nv;
                sense_d = fin_i;
                if (nv >= VMAX) begin
                  st_d   = LOCKED;
                  lock_d = 1'b1;
                  inv_d  = fin_i;
                end
              end
            end
          end
        end
        LOCKED: begin
          if (!auto_en) begin
            st_d    = HUNT;
            vcnt_d  = '0;
            sense_d = 1'b0;
            lock_d  = 1'b0;
            inv_d   = 1'b0;
          end
        end
        default: st_d = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/usb_rx_polarity.sv
// USB RX lane polarity correction, registered XOR datapath.
// Auto-detection is built only with USB_POL_AUTO_EN defined.
import usb_phy_pkg::*;

module usb_rx_polarity #(
  parameter int LANES    = 1,
  parameter int VOTE_CNT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*10-1:0] in,
  input  logic                in_valid,
  input  logic [LANES-1:0]    inv_manual,
  input  logic                auto_en,
  input  logic                clr,
  output logic [LANES*10-1:0] out,
  output logic                out_valid,
  output logic [LANES-1:0]    pol_lock,
  output logic [LANES-1:0]    pol_inv
);

  logic [LANES-1:0]    sel;
  logic [LANES*10-1:0] mask;

`ifdef USB_POL_AUTO_EN
  // Detectors watch raw input so the decision never feeds back
  for (genvar n = 0; n < LANES; n++) begin : g_det
    usb_pol_det #(
      .VOTE_CNT(VOTE_CNT)
    ) u_det (
      .clk     (clk),
      .rst     (rst),
      .sym     (in[10*n +: 10]),
      .valid   (in_valid),
      .auto_en (auto_en),
      .clr     (clr),
      .lock    (pol_lock[n]),
      .inv     (pol_inv[n])
    );
    assign sel[n] = (auto_en & pol_lock[n]) ? pol_inv[n]
                                            : inv_manual[n];
  end
`else
  logic unused;
  assign unused   = ^{auto_en, clr, 4'(VOTE_CNT)};
  assign pol_lock = '0;
  assign pol_inv  = '0;
  assign sel      = inv_manual;
`endif

  for (genvar n = 0; n < LANES; n++) begin : g_mask
    assign mask[10*n +: 10] = {10{sel[n]}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= in ^ mask;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_usb_rx_polarity.sv
// Scoreboard bench for usb_rx_polarity, LANES=2, VOTE_CNT=2.
// Detection checks compile only with USB_POL_AUTO_EN.
module tb_usb_rx_polarity;

  localparam logic [9:0] K_N = 10'h0FA;
  localparam logic [9:0] K_P = 10'h305;
  localparam logic [9:0] DN  = 10'h155;
  localparam logic [9:0] DI  = 10'h2AA;
  localparam logic [9:0] LNK = 10'h1E3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] in = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  inv_manual = '0;
  logic        auto_en = 1'b0;
  logic        clr = 1'b0;
  logic [19:0] out;
  logic        out_valid;
  logic [1:0]  pol_lock;
  logic [1:0]  pol_inv;

  int n_chk = 0;
  int n_fail = 0;
  logic [19:0] q[$];

  usb_rx_polarity #(
    .LANES    (2),
    .VOTE_CNT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .inv_manual (inv_manual),
    .auto_en    (auto_en),
    .clr        (clr),
    .out        (out),
    .out_valid  (out_valid),
    .pol_lock   (pol_lock),
    .pol_inv    (pol_inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [19:0] got,
                     input logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic st(input string nm,
                    input logic [1:0] l,
                    input logic [1:0] i);
    chk({nm, "_lock"}, 20'(pol_lock), 20'(l));
    chk({nm, "_inv"}, 20'(pol_inv), 20'(i));
  endtask

  // m is the hand-derived inversion each lane must apply
  task automatic send(input logic [9:0] a,
                      input logic [9:0] b,
                      input logic [1:0] m);
    @(negedge clk);
    in       = {b, a};
    in_valid = 1'b1;
    q.push_back({b ^ {10{m[1]}}, a ^ {10{m[0]}}});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic ts(input logic [9:0] d0,
                    input logic [9:0] d1,
                    input logic [9:0] l1,
                    input logic [1:0] m,
                    input int nchk);
    logic [9:0] k;
    for (int i = 0; i < 4; i++) begin
      k = i[0] ? K_P : K_N;
      send(k, k, m);
    end
    send(LNK, LNK, m);
    for (int i = 0; i < nchk; i++)
      send(d0, (i == 9) ? l1 : d1, m);
  endtask

  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && out_valid) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL out_extra got=%h exp=none", out);
        end else begin
          e = q.pop_front();
          if (out !== e) begin
            n_fail++;
            $display("FAIL out got=%h exp=%h", out, e);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_out", out, 20'h0);
    chk("rst_ov", 20'(out_valid), 20'h0);
    st("rst", 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    inv_manual = 2'b11;
    send(K_N, K_N, 2'b11);
    inv_manual = 2'b01;
    send(DN, K_N, 2'b01);
    inv_manual = 2'b00;
    send(DN, DI, 2'b00);
    idle();

`ifdef USB_POL_AUTO_EN
    auto_en = 1'b1;
    clr_pulse();
    st("clr0", 2'b00, 2'b00);

    ts(DI, DI, DI, 2'b00, 10);
    idle();
    st("ts1", 2'b00, 2'b00);
    ts(DI, DI, DI, 2'b00, 10);
    idle();
    st("ts2", 2'b11, 2'b11);
    send(DN, DN, 2'b11);
    send(K_N, DN, 2'b11);
    idle();

    @(negedge clk);
    auto_en = 1'b0;
    @(negedge clk);
    st("auto_off", 2'b00, 2'b00);
    auto_en = 1'b1;

    ts(DN, DN, DI, 2'b00, 10);
    idle();
    st("mix", 2'b00, 2'b00);
    ts(DI, DI, DI, 2'b00, 10);
    idle();
    st("flip", 2'b00, 2'b00);
    ts(DI, DI, DI, 2'b00, 10);
    idle();
    st("relock", 2'b11, 2'b11);

    clr_pulse();
    st("clr1", 2'b00, 2'b00);
    ts(DN, DI, DI, 2'b00, 10);
    ts(DN, DI, DI, 2'b00, 10);
    idle();
    st("split", 2'b11, 2'b10);
    send(DN, DN, 2'b10);
    idle();

    ts(DN, DI, DI, 2'b10, 5);
    clr_pulse();
    st("clr_mid", 2'b00, 2'b00);
    for (int i = 0; i < 5; i++)
      send(DN, DI, 2'b00);
    idle();
    st("clr_rest", 2'b00, 2'b00);
    ts(DN, DI, DI, 2'b00, 10);
    idle();
    st("clr_one", 2'b00, 2'b00);

    ts(DN, DI, DI, 2'b00, 5);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rstm_out", out, 20'h0);
    chk("rstm_ov", 20'(out_valid), 20'h0);
    st("rst_mid", 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++)
      send(DN, DI, 2'b00);
    idle();
    st("rst_rest", 2'b00, 2'b00);
    ts(DN, DI, DI, 2'b00, 10);
    idle();
    st("rst_one", 2'b00, 2'b00);
    ts(DN, DI, DI, 2'b00, 10);
    idle();
    st("rst_relock", 2'b11, 2'b10);
`else
    auto_en = 1'b1;
    ts(DI, DI, DI, 2'b00, 10);
    ts(DI, DI, DI, 2'b00, 10);
    idle();
    st("noauto", 2'b00, 2'b00);
    inv_manual = 2'b10;
    ts(DI, DN, DN, 2'b10, 10);
    idle();
    st("noauto_m", 2'b00, 2'b00);
    clr_pulse();
    send(DN, DN, 2'b10);
    idle();
    st("noauto_clr", 2'b00, 2'b00);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 20'(q.size()), 20'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
